logic_reduce_acc: RTL and testbench
===================================

# logic_reduce_acc

Parametrised, multi-cycle bitwise reduction unit: accepts a programmed number of WIDTH-bit operands over a valid/ready stream and folds them with a selectable bitwise operator (AND, OR, XOR, XNOR) into a registered accumulator. It is the sequential successor to the single-cycle bitwise gate blocks. Its per-bit datapath is built from the team's C2 multiplexer logic cells; control is plain registers. It sits between an operand source and a result consumer, both speaking valid/ready.

## Interface

- WIDTH, 8, operand/result width in bits (>=1)
- COUNT_W, 4, width of operand-count field; max operands per job = 2^COUNT_W - 1

- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  job request; accepted only in IDLE
- op  in  2  operator, sampled with start: 00 AND, 01 OR, 10 XOR, 11 XNOR
- num  in  COUNT_W  operand count, sampled with start
- in_valid  in  1  operand valid
- in_data  in  WIDTH  operand
- in_ready  out  1  unit accepts operand this cycle
- out_valid  out  1  result valid
- out_data  out  WIDTH  result
- out_ready  in  1  consumer accepts result
- busy  out  1  high whenever state != IDLE

## Operation

- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=0, out_valid=0. On start=1: latch op and num, load acc with operator identity (AND/XNOR: all-ones; OR/XOR: all-zeros), clear count. Go to ACCUM if num!=0, else DONE.
- ACCUM: in_ready=1. Transfer = in_valid & in_ready. On transfer: acc <= acc OP in_data (bitwise, all WIDTH bits), count++. When transfer occurs with count == num-1, go to DONE. in_valid low leaves state, acc, and count unchanged.
- DONE: out_valid=1, out_data=acc, in_ready=0. On out_ready=1, go to IDLE. The result is held stable until accepted.
- start outside IDLE is ignored, including start in the DONE cycle that hands off the result. op and num changes outside a start in IDLE have no effect.
- Count arithmetic is COUNT_W bits unsigned. count never exceeds num-1, so no wrap.
- Reset (any state, asynchronous): state=IDLE, acc=0, count=0, latched op=00, latched num=0. All outputs go to 0 immediately: in_ready=0, out_valid=0, out_data=0, busy=0. A job in flight is discarded with no partial result.

## Timing

- All outputs are registered or decoded from state only. No combinational input-to-output path.
- start sampled at edge k: busy=1 and in_ready=1 (num!=0) after edge k.
- num=0: out_valid=1 after edge k (1-cycle latency), out_data=identity.
- Final transfer at edge m: out_valid=1 and in_ready=0 after edge m. Minimum job latency is num+1 cycles from start to out_valid.
- out_valid & out_ready at edge n: IDLE after edge n. The earliest next start is sampled at edge n+1.
- out_data after acceptance holds its last value until the next start reloads acc.

## Test plan

- AND, WIDTH=8, num=3, operands F0,3C,FF back-to-back -> out_valid after 3rd transfer, out_data=30. in_ready drops the same cycle out_valid rises.
- XOR, num=4, operands 01,02,04,08 with in_valid low 2 cycles between each -> out_data=0F. count holds during gaps, and exactly 4 transfers are accepted.
- num=0: op=AND -> out_data=FF one cycle after start; op=OR -> out_data=00. in_ready never asserts.
- XNOR, num=2, operands A5,5A -> out_data=00. Hold out_ready=0 for 5 cycles while pulsing start: out_valid and out_data stay constant, start is ignored, and IDLE follows the cycle after out_ready=1.
- Drive rst_n low mid-ACCUM after 2 of 5 OR operands -> in_ready, busy, out_valid, out_data all 0 without a clock edge. After release, a new OR job with num=1 on operand 81 yields 81 with no residue.
- Back-to-back jobs: start asserted in the cycle out_valid & out_ready -> ignored. start in the following cycle is accepted and completes correctly.

Source files
------------

// File: rtl/logic_reduce_acc_if.sv
// ---------------------------------------------------------------------------
// logic_reduce_acc_if
// Bundles the job-control, operand stream and result stream of the
// logic_reduce_acc reduction unit.
//   start, op, num        : job request with operator and operand count
//   in_valid/in_ready     : operand stream handshake, in_data operand
//   out_valid/out_ready   : result stream handshake, out_data result
//   busy                  : unit is not idle
// modport master : operand source / result consumer side
// modport slave  : the reduction unit itself
// ---------------------------------------------------------------------------
interface logic_reduce_acc_if #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 4
) ();
    logic               start;
    logic [1:0]         op;
    logic [COUNT_W-1:0] num;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;
    logic               busy;

    modport master (
        output start, op, num, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  start, op, num, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/logic_reduce_acc.sv
// ---------------------------------------------------------------------------
// logic_reduce_acc
// Multi-cycle bitwise reduction unit. A job is requested with start, which
// latches the operator (00 AND, 01 OR, 10 XOR, 11 XNOR) and the operand
// count. The unit then accepts that many WIDTH-bit operands over a
// valid/ready stream, folding each into a registered accumulator, and
// presents the result on a valid/ready output until it is accepted.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : logic_reduce_acc_if slave modport (job, operand, result, busy)
// All outputs come straight from registers, so there is no combinational
// path from any input to any output.
// ---------------------------------------------------------------------------
module logic_reduce_acc #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_reduce_acc_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] num_q;
    logic [1:0]         op_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [WIDTH-1:0]   fold;

    // Per-bit operator mux: each result bit selects one of the four
    // two-input functions of the accumulator bit and the operand bit,
    // using the operator latched at start.
    always_comb begin
        fold = acc;
        unique case (op_q)
            OP_AND:  fold = acc & bus.in_data;
            OP_OR:   fold = acc | bus.in_data;
            OP_XOR:  fold = acc ^ bus.in_data;
            OP_XNOR: fold = ~(acc ^ bus.in_data);
            default: fold = acc;
        endcase
    end

    // Control FSM with registered handshake outputs. The accumulator is
    // loaded with the operator identity on start so that the first operand
    // passes through unchanged. A job with num==0 goes straight to DONE
    // and returns the identity. start is only looked at in IDLE, so a start
    // in the result hand-off cycle is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            count       <= '0;
            num_q       <= '0;
            op_q        <= OP_AND;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        num_q  <= bus.num;
                        count  <= '0;
                        busy_q <= 1'b1;
                        if (bus.op == OP_AND || bus.op == OP_XNOR) begin
                            acc <= '1;
                        end else begin
                            acc <= '0;
                        end
                        if (bus.num != '0) begin
                            state      <= ACCUM;
                            in_ready_q <= 1'b1;
                        end else begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    // in_ready is always high here, so in_valid alone
                    // marks a transfer.
                    if (bus.in_valid) begin
                        acc   <= fold;
                        count <= count + 1'b1;
                        if (count == num_q - 1'b1) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_logic_reduce_acc.sv
// ---------------------------------------------------------------------------
// tb_logic_reduce_acc
// Directed bench for logic_reduce_acc (WIDTH=8, COUNT_W=4). Inputs are
// driven at the falling edge and outputs are sampled at the falling edge,
// so every rising edge sees stable inputs and every sample sees settled
// registered outputs.
// ---------------------------------------------------------------------------
module tb_logic_reduce_acc;

    localparam int WIDTH   = 8;
    localparam int COUNT_W = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic_reduce_acc_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) bus ();

    logic_reduce_acc #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then wait for the
    // next falling edge so that exactly one rising edge consumes them.
    task automatic applyStimulus(input logic s, input logic [1:0] o,
                                 input logic [COUNT_W-1:0] n, input logic v,
                                 input logic [WIDTH-1:0] d, input logic r);
        bus.start     = s;
        bus.op        = o;
        bus.num       = n;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        @(negedge clk);
    endtask

    // Snapshot of all four outputs against expected values.
    task automatic checkAll(input string tag, input logic rdy, input logic vld,
                            input logic [WIDTH-1:0] data, input logic bsy);
        checkOutput({tag, ".in_ready"},  32'(bus.in_ready),  32'(rdy));
        checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'(vld));
        checkOutput({tag, ".out_data"},  32'(bus.out_data),  32'(data));
        checkOutput({tag, ".busy"},      32'(bus.busy),      32'(bsy));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.num = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkAll("reset", 1'b0, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        applyStimulus(0, 2'b00, 4'd0, 0, 8'h00, 0);
        checkAll("idle", 1'b0, 1'b0, 8'h00, 1'b0);

        // AND of F0,3C,FF back to back -> 30
        applyStimulus(1, 2'b00, 4'd3, 0, 8'h00, 0);
        checkAll("and.start", 1'b1, 1'b0, 8'hFF, 1'b1);
        applyStimulus(0, 2'b11, 4'd9, 1, 8'hF0, 0);
        applyStimulus(0, 2'b11, 4'd9, 1, 8'h3C, 0);
        checkAll("and.mid", 1'b1, 1'b0, 8'h30, 1'b1);
        applyStimulus(0, 2'b00, 4'd0, 1, 8'hFF, 0);
        checkAll("and.done", 1'b0, 1'b1, 8'h30, 1'b1);
        applyStimulus(0, 2'b00, 4'd0, 0, 8'h00, 1);
        checkAll("and.accepted", 1'b0, 1'b0, 8'h30, 1'b0);

        // XOR of 01,02,04,08 with two idle cycles between operands -> 0F
        applyStimulus(1, 2'b10, 4'd4, 0, 8'h00, 0);
        checkAll("xor.start", 1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            logic [WIDTH-1:0] operand;
            logic [WIDTH-1:0] partial;
            operand = WIDTH'(1) << i;
            partial = (WIDTH'(1) << (i + 1)) - 1'b1;
            applyStimulus(0, 2'b00, 4'd0, 1, operand, 0);
            if (i < 3) begin
                applyStimulus(0, 2'b00, 4'd0, 0, 8'hEE, 0);
                applyStimulus(0, 2'b00, 4'd0, 0, 8'hEE, 0);
                checkAll($sformatf("xor.gap%0d", i), 1'b1, 1'b0, partial, 1'b1);
            end
        end
        checkAll("xor.done", 1'b0, 1'b1, 8'h0F, 1'b1);
        // A fifth operand offered in DONE must not be folded in.
        applyStimulus(0, 2'b00, 4'd0, 1, 8'h80, 0);
        checkAll("xor.extra", 1'b0, 1'b1, 8'h0F, 1'b1);
        applyStimulus(0, 2'b00, 4'd0, 0, 8'h00, 1);
        checkAll("xor.accepted", 1'b0, 1'b0, 8'h0F, 1'b0);

        // num=0 returns the identity one cycle after start
        applyStimulus(1, 2'b00, 4'd0, 0, 8'h00, 0);
        checkAll("zero.and", 1'b0, 1'b1, 8'hFF, 1'b1);
        applyStimulus(0, 2'b00, 4'd0, 0, 8'h00, 1);
        applyStimulus(1, 2'b01, 4'd0, 1, 8'h77, 0);
        checkAll("zero.or", 1'b0, 1'b1, 8'h00, 1'b1);
        applyStimulus(0, 2'b00, 4'd0, 0, 8'h00, 1);
        checkAll("zero.accepted", 1'b0, 1'b0, 8'h00, 1'b0);

        // XNOR of A5,5A -> 00, then result held under back-pressure
        applyStimulus(1, 2'b11, 4'd2, 0, 8'h00, 0);
        applyStimulus(0, 2'b00, 4'd0, 1, 8'hA5, 0);
        checkAll("xnor.mid", 1'b1, 1'b0, 8'hA5, 1'b1);
        applyStimulus(0, 2'b00, 4'd0, 1, 8'h5A, 0);
        for (int i = 0; i < 5; i++) begin
            checkAll($sformatf("xnor.hold%0d", i), 1'b0, 1'b1, 8'h00, 1'b1);
            applyStimulus(i[0] ? 1'b0 : 1'b1, 2'b01, 4'd0, 1, 8'hFF, 0);
        end
        checkAll("xnor.hold5", 1'b0, 1'b1, 8'h00, 1'b1);
        applyStimulus(0, 2'b00, 4'd0, 0, 8'h00, 1);
        checkAll("xnor.accepted", 1'b0, 1'b0, 8'h00, 1'b0);

        // Asynchronous reset in the middle of an OR job
        applyStimulus(1, 2'b01, 4'd5, 0, 8'h00, 0);
        applyStimulus(0, 2'b00, 4'd0, 1, 8'h0F, 0);
        applyStimulus(0, 2'b00, 4'd0, 1, 8'hF0, 0);
        checkAll("rst.before", 1'b1, 1'b0, 8'hFF, 1'b1);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkAll("rst.async", 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 2'b01, 4'd1, 0, 8'h00, 0);
        checkAll("rst.newstart", 1'b1, 1'b0, 8'h00, 1'b1);
        applyStimulus(0, 2'b00, 4'd0, 1, 8'h81, 0);
        checkAll("rst.result", 1'b0, 1'b1, 8'h81, 1'b1);

        // Start in the hand-off cycle is ignored; the next cycle is taken
        applyStimulus(1, 2'b00, 4'd0, 0, 8'h00, 1);
        checkAll("b2b.ignored", 1'b0, 1'b0, 8'h81, 1'b0);
        applyStimulus(1, 2'b10, 4'd1, 0, 8'h00, 0);
        checkAll("b2b.start", 1'b1, 1'b0, 8'h00, 1'b1);
        applyStimulus(0, 2'b00, 4'd0, 1, 8'h55, 0);
        checkAll("b2b.result", 1'b0, 1'b1, 8'h55, 1'b1);
        applyStimulus(0, 2'b00, 4'd0, 0, 8'h00, 1);
        checkAll("b2b.accepted", 1'b0, 1'b0, 8'h55, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
